// File: rtl/dsp_pipe_stage.sv
// Stallable DEPTH-stage pipeline register with per-stage valid, bubble collapse and flush; OCC port with DSP_PIPE_OCC_EN.
// Latency: DEPTH cycles from IN_VALID to OUT_VALID on an empty pipe; one item per cycle sustained.
// Backpressure: IN_READY falls only when every stage is full and OUT_READY is low; CE=0 or FLUSH blocks both handshakes.
module dsp_pipe_stage #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 2,
    parameter int CLEAR_DATA = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA
`ifdef DSP_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [DEPTH-1:0]            can_acc;
    logic [DEPTH-1:0]            up_vld;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_d;
    logic [DEPTH-1:0][WIDTH-1:0] up_dat;
    logic                        in_xfer;

    // Ready ripples from the tail toward the head: an empty stage can always
    // take a new item, so a stalled tail never blocks bubbles upstream of it.
    always_comb begin
        can_acc = '0;
        can_acc[DEPTH-1] = ~v_q[DEPTH-1] | OUT_READY;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            can_acc[i] = ~v_q[i] | can_acc[i+1];
        end
        IN_READY  = CE & ~FLUSH & can_acc[0];
        OUT_VALID = CE & ~FLUSH & v_q[DEPTH-1];
        in_xfer   = IN_VALID & IN_READY;
    end

    // What each stage would load if it advances: the input port for stage 0,
    // the previous stage otherwise.
    always_comb begin
        up_vld    = '0;
        up_dat    = '0;
        up_vld[0] = in_xfer;
        up_dat[0] = IN_DATA;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld[i] = v_q[i-1];
            up_dat[i] = d_q[i-1];
        end
    end

    // Next state: flush drops every valid but leaves data alone; otherwise a
    // stage that can accept takes upstream valid, and data only on a real item.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (CE && FLUSH) begin
            v_d = '0;
        end else if (CE) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (can_acc[i]) begin
                    v_d[i] = up_vld[i];
                    if (up_vld[i]) begin
                        d_d[i] = up_dat[i];
                    end
                end
            end
        end
    end

    // Valid bits always clear on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    generate
        if (CLEAR_DATA != 0) begin : g_data_rst
            // Data registers cleared on reset.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    d_q <= '0;
                end else begin
                    d_q <= d_d;
                end
            end
        end else begin : g_data_norst
            // Data registers carry no reset; only valid bits define content.
            always_ff @(posedge CLK) begin
                d_q <= d_d;
            end
        end
    endgenerate

    assign OUT_DATA = d_q[DEPTH-1];

`ifdef DSP_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             out_xfer;

    // Occupancy tracks transfers at both ports; simultaneous in/out cancel.
    always_comb begin
        out_xfer = OUT_VALID & OUT_READY;
        occ_d    = occ_q;
        if (CE && FLUSH) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;
`endif

endmodule

// File: tb/tb_dsp_pipe_stage.sv
module tb_dsp_pipe_stage;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        flush;

    logic        a_in_vld, a_in_rdy, a_out_vld, a_out_rdy;
    logic [17:0] a_in_dat, a_out_dat;
    logic        b_in_vld, b_in_rdy, b_out_vld, b_out_rdy;
    logic [17:0] b_in_dat, b_out_dat;
`ifdef DSP_PIPE_OCC_EN
    logic [1:0]  a_occ;
    logic [2:0]  b_occ;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dsp_pipe_stage #(.WIDTH(18), .DEPTH(3), .CLEAR_DATA(1)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .FLUSH(flush),
        .IN_VALID(a_in_vld), .IN_READY(a_in_rdy), .IN_DATA(a_in_dat),
        .OUT_VALID(a_out_vld), .OUT_READY(a_out_rdy), .OUT_DATA(a_out_dat)
`ifdef DSP_PIPE_OCC_EN
        , .OCC(a_occ)
`endif
    );

    dsp_pipe_stage #(.WIDTH(18), .DEPTH(4), .CLEAR_DATA(1)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .FLUSH(flush),
        .IN_VALID(b_in_vld), .IN_READY(b_in_rdy), .IN_DATA(b_in_dat),
        .OUT_VALID(b_out_vld), .OUT_READY(b_out_rdy), .OUT_DATA(b_out_dat)
`ifdef DSP_PIPE_OCC_EN
        , .OCC(b_occ)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        #2;
        n_cmp++; if (a_out_vld !== 1'b0) begin n_bad++; $display("FAIL rst_out_vld: got %b expected 0", a_out_vld); end
        n_cmp++; if (a_out_dat !== 18'h0) begin n_bad++; $display("FAIL rst_out_dat: got %h expected 0", a_out_dat); end
        n_cmp++; if (a_in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_in_rdy: got %b expected 1", a_in_rdy); end
        n_cmp++; if (b_out_vld !== 1'b0) begin n_bad++; $display("FAIL rst_b_out_vld: got %b expected 0", b_out_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            a_in_vld = (c < 3);
            a_in_dat = 18'h11 * 18'(c + 1);
            #1;
            if (c == 3) begin
                n_cmp++; if (a_out_vld !== 1'b1) begin n_bad++; $display("FAIL fill_out_vld: got %b expected 1", a_out_vld); end
                n_cmp++; if (a_out_dat !== 18'h11) begin n_bad++; $display("FAIL fill_out_dat: got %h expected 11", a_out_dat); end
                n_cmp++; if (a_in_rdy !== 1'b0) begin n_bad++; $display("FAIL fill_in_rdy: got %b expected 0", a_in_rdy); end
`ifdef DSP_PIPE_OCC_EN
                n_cmp++; if (a_occ !== 2'd3) begin n_bad++; $display("FAIL fill_occ: got %0d expected 3", a_occ); end
`endif
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_out_vld !== 1'b0) begin n_bad++; $display("FAIL arst_out_vld: got %b expected 0", a_out_vld); end
        n_cmp++; if (a_out_dat !== 18'h0) begin n_bad++; $display("FAIL arst_out_dat: got %h expected 0", a_out_dat); end
        n_cmp++; if (a_in_rdy !== 1'b1) begin n_bad++; $display("FAIL arst_in_rdy: got %b expected 1", a_in_rdy); end
`ifdef DSP_PIPE_OCC_EN
        n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL arst_occ: got %0d expected 0", a_occ); end
`endif
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (a_in_rdy !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_rdy: got %b expected 1", a_in_rdy); end
        n_cmp++; if (a_out_vld !== 1'b0) begin n_bad++; $display("FAIL post_rst_out_vld: got %b expected 0", a_out_vld); end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int rcv = 0;
        int first = -1;
        int last = -1;
        a_out_rdy = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            a_in_vld = (sent < 16);
            a_in_dat = 18'(sent + 1);
            #1;
            if (a_in_vld) begin
                n_cmp++; if (a_in_rdy !== 1'b1) begin n_bad++; $display("FAIL stream_in_rdy: cycle %0d got %b expected 1", c, a_in_rdy); end
                if (a_in_rdy) sent++;
            end
            if (a_out_vld) begin
                if (first < 0) first = c;
                last = c;
                n_cmp++; if (a_out_dat !== 18'(rcv + 1)) begin n_bad++; $display("FAIL stream_dat: got %h expected %h", a_out_dat, 18'(rcv + 1)); end
                rcv++;
            end
        end
        a_in_vld = 1'b0;
        n_cmp++; if (first !== 3) begin n_bad++; $display("FAIL stream_latency: got cycle %0d expected 3", first); end
        n_cmp++; if (rcv !== 16) begin n_bad++; $display("FAIL stream_count: got %0d expected 16", rcv); end
        n_cmp++; if (last - first !== 15) begin n_bad++; $display("FAIL stream_gapless: got span %0d expected 15", last - first); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int rcv = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            a_in_vld  = (sent < 5);
            a_in_dat  = 18'h101 + 18'(sent);
            a_out_rdy = (c >= 5);
            #1;
            if (c == 4) begin
                n_cmp++; if (a_in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_in_rdy: got %b expected 0", a_in_rdy); end
                n_cmp++; if (sent !== 3) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 3", sent); end
`ifdef DSP_PIPE_OCC_EN
                n_cmp++; if (a_occ !== 2'd3) begin n_bad++; $display("FAIL bp_occ: got %0d expected 3", a_occ); end
`endif
            end
            if (a_in_vld && a_in_rdy) sent++;
            if (a_out_vld && a_out_rdy) begin
                if (first < 0) first = c;
                last = c;
                n_cmp++; if (a_out_dat !== 18'h101 + 18'(rcv)) begin n_bad++; $display("FAIL bp_dat: got %h expected %h", a_out_dat, 18'h101 + 18'(rcv)); end
                rcv++;
            end
        end
        a_in_vld = 1'b0;
        n_cmp++; if (rcv !== 5) begin n_bad++; $display("FAIL bp_count: got %0d expected 5", rcv); end
        n_cmp++; if (first !== 5 || last !== 9) begin n_bad++; $display("FAIL bp_timing: got %0d..%0d expected 5..9", first, last); end
    endtask

    task automatic test_bubble_collapse();
        b_out_rdy = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            b_in_vld  = (c == 0) || (c >= 4 && c <= 7);
            b_in_dat  = (c == 0) ? 18'h201 : 18'h202 + 18'(c - 4);
            b_out_rdy = (c >= 8);
            #1;
            if (c == 4) begin
                n_cmp++; if (b_out_vld !== 1'b1 || b_out_dat !== 18'h201) begin n_bad++; $display("FAIL bub_stall: got %b/%h expected 1/201", b_out_vld, b_out_dat); end
            end
            if (c >= 4 && c <= 6) begin
                n_cmp++; if (b_in_rdy !== 1'b1) begin n_bad++; $display("FAIL bub_accept: cycle %0d got %b expected 1", c, b_in_rdy); end
            end
            if (c == 7) begin
                n_cmp++; if (b_in_rdy !== 1'b0) begin n_bad++; $display("FAIL bub_full: got %b expected 0", b_in_rdy); end
`ifdef DSP_PIPE_OCC_EN
                n_cmp++; if (b_occ !== 3'd4) begin n_bad++; $display("FAIL bub_occ: got %0d expected 4", b_occ); end
`endif
            end
            if (c >= 8 && c <= 11) begin
                n_cmp++; if (b_out_vld !== 1'b1 || b_out_dat !== 18'h201 + 18'(c - 8)) begin n_bad++; $display("FAIL bub_drain: got %b/%h expected 1/%h", b_out_vld, b_out_dat, 18'h201 + 18'(c - 8)); end
            end
            if (c == 12) begin
                n_cmp++; if (b_out_vld !== 1'b0) begin n_bad++; $display("FAIL bub_empty: got %b expected 0", b_out_vld); end
            end
        end
        b_in_vld = 1'b0;
    endtask

    task automatic test_ce_freeze();
        int sent = 0;
        int rcv = 0;
        a_out_rdy = 1'b1;
        for (int c = 0; c < 21; c++) begin
            @(posedge clk); #1;
            ce       = !(c >= 4 && c <= 8);
            a_in_vld = (sent < 10);
            a_in_dat = 18'h301 + 18'(sent);
            #1;
            if (!ce) begin
                n_cmp++; if (a_in_rdy !== 1'b0) begin n_bad++; $display("FAIL ce_in_rdy: got %b expected 0", a_in_rdy); end
                n_cmp++; if (a_out_vld !== 1'b0) begin n_bad++; $display("FAIL ce_out_vld: got %b expected 0", a_out_vld); end
                n_cmp++; if (a_out_dat !== 18'h302) begin n_bad++; $display("FAIL ce_out_dat: got %h expected 302", a_out_dat); end
`ifdef DSP_PIPE_OCC_EN
                n_cmp++; if (a_occ !== 2'd3) begin n_bad++; $display("FAIL ce_occ: got %0d expected 3", a_occ); end
`endif
            end
            if (a_in_vld && a_in_rdy) sent++;
            if (a_out_vld && a_out_rdy) begin
                n_cmp++; if (a_out_dat !== 18'h301 + 18'(rcv)) begin n_bad++; $display("FAIL ce_dat: got %h expected %h", a_out_dat, 18'h301 + 18'(rcv)); end
                rcv++;
            end
        end
        ce = 1'b1;
        a_in_vld = 1'b0;
        n_cmp++; if (rcv !== 10) begin n_bad++; $display("FAIL ce_count: got %0d expected 10", rcv); end
    endtask

    task automatic test_flush();
        int rcv = 0;
        int first = -1;
        logic [17:0] got = '0;
        a_out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            a_in_vld  = (c <= 1) || (c == 3);
            a_in_dat  = (c == 3) ? 18'h4FF : 18'h401 + 18'(c);
            flush     = (c == 3);
            a_out_rdy = (c == 3);
            if (c == 4) a_in_vld = 1'b0;
            #1;
            if (c == 3) begin
                n_cmp++; if (a_in_rdy !== 1'b0) begin n_bad++; $display("FAIL fl_in_rdy: got %b expected 0", a_in_rdy); end
                n_cmp++; if (a_out_vld !== 1'b0) begin n_bad++; $display("FAIL fl_out_vld: got %b expected 0", a_out_vld); end
`ifdef DSP_PIPE_OCC_EN
                n_cmp++; if (a_occ !== 2'd2) begin n_bad++; $display("FAIL fl_occ_pre: got %0d expected 2", a_occ); end
`endif
            end
            if (c == 4) begin
                n_cmp++; if (a_out_vld !== 1'b0) begin n_bad++; $display("FAIL fl_after_vld: got %b expected 0", a_out_vld); end
                n_cmp++; if (a_in_rdy !== 1'b1) begin n_bad++; $display("FAIL fl_after_rdy: got %b expected 1", a_in_rdy); end
`ifdef DSP_PIPE_OCC_EN
                n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL fl_occ: got %0d expected 0", a_occ); end
`endif
            end
        end
        for (int c = 5; c < 14; c++) begin
            @(posedge clk); #1;
            a_in_vld  = (c == 5);
            a_in_dat  = 18'h2A;
            a_out_rdy = 1'b1;
            #1;
            if (a_out_vld) begin
                if (first < 0) begin first = c; got = a_out_dat; end
                rcv++;
            end
        end
        a_in_vld = 1'b0;
        n_cmp++; if (first !== 8) begin n_bad++; $display("FAIL fl_latency: got cycle %0d expected 8", first); end
        n_cmp++; if (got !== 18'h2A) begin n_bad++; $display("FAIL fl_dat: got %h expected 2a", got); end
        n_cmp++; if (rcv !== 1) begin n_bad++; $display("FAIL fl_count: got %0d expected 1", rcv); end
    endtask

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b1;
        flush     = 1'b0;
        a_in_vld  = 1'b0;
        a_in_dat  = '0;
        a_out_rdy = 1'b0;
        b_in_vld  = 1'b0;
        b_in_dat  = '0;
        b_out_rdy = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_ce_freeze();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsp_pipe_stage.md
# dsp_pipe_stage

Parametrised multi-stage pipeline register with valid/ready flow control. It generalises the single clock-enabled register to DEPTH stages, adds per-stage valid tracking, bubble collapsing, downstream backpressure and synchronous flush. It sits between the DSP slice input/multiplier/post-adder register points wherever a stallable, drainable pipeline is needed instead of a fixed delay.

## Interface
Parameters:
- WIDTH, 18, data width in bits (>=1)
- DEPTH, 2, number of register stages (>=1)
- CLEAR_DATA, 1, 1: data registers reset to 0; 0: only valid bits reset, data registers hold

Ports:
- CLK  input  1  clock, all state on rising edge
- RST_N  input  1  asynchronous reset, active-low
- CE  input  1  global clock enable; 0 freezes all state and blocks both handshakes
- FLUSH  input  1  synchronous flush, clears all valid bits
- IN_VALID  input  1  upstream data valid
- IN_READY  output  1  block can accept IN_DATA this cycle
- IN_DATA  input  WIDTH  upstream data
- OUT_VALID  output  1  OUT_DATA valid
- OUT_READY  input  1  downstream accepts
- OUT_DATA  output  WIDTH  data of stage DEPTH-1
- OCC  output  $clog2(DEPTH+1)  stored-item count (only with DSP_PIPE_OCC_EN)

## Operation
- Stages s[0..DEPTH-1], each holds data d[i] and valid v[i]; s[DEPTH-1] drives OUT_DATA.
- can_acc[DEPTH-1] = ~v[DEPTH-1] | OUT_READY; can_acc[i] = ~v[i] | can_acc[i+1].
- IN_READY = CE & ~FLUSH & can_acc[0]; OUT_VALID = CE & ~FLUSH & v[DEPTH-1].
- Input transfer: IN_VALID & IN_READY. Output transfer: OUT_VALID & OUT_READY.
- On edge with CE=1, FLUSH=0: each stage with can_acc[i]=1 loads from stage i-1 (stage 0 from IN_DATA/IN_VALID-transfer); v[i] takes the upstream valid. Stages with can_acc[i]=0 hold. Bubbles collapse: a stalled tail does not stall empty stages ahead of it.
- Data registers only load when the incoming valid is 1; a bubble moving in leaves d[i] unchanged.
- FLUSH=1 and CE=1 at edge: all v[i] <= 0; d[i] unchanged; no transfers occur that cycle. FLUSH with CE=0: ignored.
- CE=0: no state change, IN_READY=0, OUT_VALID=0, OUT_DATA still shows d[DEPTH-1].
- Reset (RST_N low, any time, mid-stream included): all v[i]=0 immediately; d[i]=0 if CLEAR_DATA=1. Outputs during/after reset: IN_READY=CE&~FLUSH, OUT_VALID=0, OUT_DATA=0 (CLEAR_DATA=1), OCC=0.
- No combinational path IN_VALID->IN_READY; combinational path OUT_READY->IN_READY exists (depth DEPTH of OR gates).

## Timing
- Latency: item accepted at edge k (empty pipe, OUT_READY=1) presents OUT_VALID after edge k+DEPTH-1, i.e. DEPTH cycles from IN_VALID assertion to OUT_VALID.
- Throughput: one item per cycle sustained when OUT_READY=1 and CE=1.
- Capacity: exactly DEPTH items; full with OUT_READY=0 gives IN_READY=0.
- Full pipe, OUT_READY=1 same cycle as IN_VALID=1: both transfers occur, occupancy unchanged.
- Order always preserved; no duplication, no loss except by FLUSH or reset.

## Configuration
- DSP_PIPE_OCC_EN defined: OCC port present; registered counter, +1 on input transfer, -1 on output transfer, unchanged on both or neither, 0 on FLUSH (CE=1) or reset; range 0..DEPTH, always equals popcount of v[].
- Not defined: OCC port and counter absent; all other behaviour identical.

## Test plan
- Reset: WIDTH=18, DEPTH=3, hold RST_N=0 mid-stream with pipe full -> OUT_VALID=0, OUT_DATA=0, OCC=0 asynchronously, IN_READY=1 after release with CE=1.
- Streaming: DEPTH=3, OUT_READY=1, send 0x00001..0x00010 back-to-back -> first OUT_VALID 3 cycles after first IN_VALID, 16 items in order, one per cycle.
- Backpressure/fill: OUT_READY=0, send 5 items into DEPTH=3 -> 3 accepted, IN_READY=0 after third, OCC=3; raise OUT_READY -> items 1..5 emerge in order, no gaps once refilled.
- Bubble collapse: DEPTH=4, one item stalled at output (OUT_READY=0), then 3 more sent one per cycle -> all accepted on consecutive cycles, IN_READY drops only at 4 stored.
- CE freeze: mid-stream drop CE for 5 cycles -> IN_READY=0, OUT_VALID=0, OCC and OUT_DATA frozen; resume -> stream continues with no loss or duplicate.
- Flush: pipe holding 2 items, FLUSH=1 one cycle with IN_VALID=1 -> no transfer that cycle, OCC=0 and OUT_VALID=0 next cycle; subsequent item 0x2A emerges after DEPTH cycles.
